// File: rtl/stream_cipher_pkg.sv
// rtl/stream_cipher_pkg.sv - shared LFSR keystream definitions for the stream encryptor/decryptor pair
package stream_cipher_pkg;
  localparam int LFSR_W       = 64;
  localparam int TAP0         = 0;
  localparam int TAP1         = 1;
  localparam int TAP2         = 3;
  localparam int TAP3         = 4;
  localparam int KEY_BITS_DEF = 6;
  localparam int STEPS_DEF    = 6;

  typedef enum logic [1:0] {IDLE, GEN, KEY} dec_state_t;

  // One shift: feedback bit enters at the MSB, register shifts towards bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[TAP1] ^ s[TAP0] ^ s[TAP3] ^ s[TAP2], s[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/stream_decryptor_if.sv
// rtl/stream_decryptor_if.sv - cipher-in / plaintext-out handshake bundle
interface stream_decryptor_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/lfsr_keystream.sv
// rtl/lfsr_keystream.sv - LFSR register, step counter and key register; strobes key_valid on the last step
module lfsr_keystream
  import stream_cipher_pkg::*;
#(
  parameter int STEPS    = STEPS_DEF,
  parameter int KEY_BITS = KEY_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              run,
  output logic [7:0]        key,
  output logic              key_valid
);
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_step;

  assign lfsr_nxt  = lfsr_next(lfsr);
  assign last_step = (cnt == CNT_W'(STEPS - 1));
  assign key_valid = run && !load && last_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= '0;
      cnt  <= '0;
      key  <= '0;
    end else if (load) begin
      lfsr <= seed;
      cnt  <= '0;
    end else if (run) begin
      lfsr <= lfsr_nxt;
      if (last_step) begin
        cnt <= '0;
        // Key comes from the post-step state so key n reflects STEPS*n shifts.
        key <= 8'(lfsr_nxt[LFSR_W-1 -: KEY_BITS]);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/stream_decryptor.sv
// rtl/stream_decryptor.sv - handshaked LFSR stream decryptor: XORs regenerated keystream onto cipher bytes
module stream_decryptor
  import stream_cipher_pkg::*;
#(
  parameter int STEPS    = STEPS_DEF,
  parameter int KEY_BITS = KEY_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                load,
  stream_decryptor_if.slave   bus
);
  dec_state_t state;
  logic [7:0] key;
  logic       key_valid;
  logic       accept;
  logic       out_valid_q;
  logic [7:0] out_data_q;

  lfsr_keystream #(
    .STEPS    (STEPS),
    .KEY_BITS (KEY_BITS)
  ) u_ks (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .seed      (seed),
    .run       (state == GEN),
    .key       (key),
    .key_valid (key_valid)
  );

  // A load in the same cycle wins over any accept, so ready is masked by it.
  assign bus.in_ready  = (state == KEY) && (!out_valid_q || bus.out_ready) && !load;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else if (load) begin
      state       <= GEN;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        GEN:     if (key_valid) state <= KEY;
        KEY:     if (accept) state <= GEN;
        default: state <= IDLE;
      endcase
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data ^ key;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_decryptor.sv
// tb/tb_stream_decryptor.sv - self-checking bench for stream_decryptor
module tb_stream_decryptor;
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [63:0] seed;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  stream_decryptor_if bus();

  stream_decryptor dut (
    .clk  (clk),
    .rst  (rst),
    .seed (seed),
    .load (load),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] seed;
    logic [7:0]  cin;
    logic [7:0]  pout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] s);
    return {s[1] ^ s[0] ^ s[4] ^ s[3], s[63:1]};
  endfunction

  // Key byte n = top 6 bits of the state after 6*n shifts of the seed.
  function automatic logic [7:0] key_byte(input logic [63:0] sd, input int n);
    logic [63:0] s = sd;
    for (int i = 0; i < 6 * n; i++) s = step(s);
    return {2'b00, s[63:58]};
  endfunction

  task automatic do_load(input logic [63:0] sd);
    @(negedge clk);
    seed = sd;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (!bus.in_ready && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic stream_run(input bit rnd_ready);
    logic [63:0] sd;
    logic [63:0] s;
    logic [7:0]  pt[32];
    logic [7:0]  ct[32];
    logic [7:0]  held_d = 8'h00;
    bit          stalled = 1'b0;
    int          tx = 0, rx = 0, guard = 0, stall_bad = 0;
    sd = {$urandom, $urandom};
    s  = sd;
    for (int i = 0; i < 32; i++) begin
      pt[i] = 8'($urandom);
      for (int k = 0; k < 6; k++) s = step(s);
      ct[i] = pt[i] ^ {2'b00, s[63:58]};
    end
    do_load(sd);
    while (rx < 32 && guard < 3000) begin
      bus.out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_valid  = (tx < 32);
      bus.in_data   = (tx < 32) ? ct[tx] : 8'h00;
      #1;
      if (stalled && (!bus.out_valid || bus.out_data !== held_d)) stall_bad++;
      if (bus.out_valid && bus.out_ready) begin
        check("stream_byte", bus.out_data, pt[rx]);
        rx++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      if (bus.in_valid && bus.in_ready) tx++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_rx_count", rx, 32);
    check("stream_tx_count", tx, 32);
    check("stream_stall_stable", stall_bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          c, t_a, t_b;
    bit          seen_ready;
    logic [63:0] sa, sb, sc;

    vecs[0] = '{64'hF, 8'h5A, 8'h53};
    vecs[1] = '{64'hF, 8'hFF, 8'hF6};
    vecs[2] = '{64'hF, 8'hC0, 8'hC9};
    vecs[3] = '{64'h0, 8'hA5, 8'hA5};
    vecs[4] = '{64'h0, 8'h3C, 8'h3C};
    vecs[5] = '{64'hF, 8'h09, 8'h00};

    rst = 1'b1; load = 1'b0; seed = '0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 8'h00);
    rst = 1'b0;
    seen_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.in_ready) seen_ready = 1'b1;
    end
    check("unseeded_no_ready", seen_ready, 0);
    check("unseeded_no_output", bus.out_valid, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].seed);
      wait_ready(c);
      check("vec_load_to_ready", c, 6);
      send(vecs[i].cin);
      check("vec_out_valid", bus.out_valid, 1);
      check("vec_out_data", bus.out_data, vecs[i].pout);
    end

    do_load(64'h0);
    wait_ready(c);
    t_a = cyc;
    send(8'hA5);
    check("zero_seed_b0", bus.out_data, 8'hA5);
    wait_ready(c);
    t_b = cyc;
    send(8'h3C);
    check("zero_seed_b1", bus.out_data, 8'h3C);
    check("accept_spacing", t_b - t_a, 7);

    stream_run(1'b0);
    stream_run(1'b1);

    sa = 64'h1234_5678_9ABC_DEF0;
    sb = 64'hDEAD_BEEF_0BAD_F00D;
    do_load(sa);
    wait_ready(c);
    bus.out_ready = 1'b0;
    send(8'h11);
    check("held_valid", bus.out_valid, 1);
    check("held_data", bus.out_data, 8'h11 ^ key_byte(sa, 1));
    repeat (6) @(negedge clk);
    check("backpressure_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    check("pop_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = 8'h22; seed = sb; load = 1'b1;
    #1;
    check("load_masks_ready", bus.in_ready, 0);
    @(negedge clk);
    load = 1'b0; bus.in_valid = 1'b0;
    check("load_drops_output", bus.out_valid, 0);
    wait_ready(c);
    check("reload_to_ready", c, 6);
    send(8'h66);
    check("reload_key1", bus.out_data, 8'h66 ^ key_byte(sb, 1));

    sc = 64'h0F0F_A5A5_3C3C_9999;
    do_load(sc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midgen_rst_lfsr", dut.u_ks.lfsr, 64'h0);
    check("midgen_rst_ready", bus.in_ready, 0);
    check("midgen_rst_valid", bus.out_valid, 0);
    check("midgen_rst_data", bus.out_data, 8'h00);
    bus.in_valid = 1'b1;
    seen_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready) seen_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("after_rst_no_ready", seen_ready, 0);
    do_load(sc);
    wait_ready(c);
    check("after_rst_load_to_ready", c, 6);
    send(8'hE7);
    check("after_rst_key1", bus.out_data, 8'hE7 ^ key_byte(sc, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_decryptor.md
Name: stream_decryptor

Overview:
- Receive-side counterpart of the LFSR byte encryptor: regenerates the same 64-bit LFSR keystream from a shared seed and XORs it onto incoming cipher bytes to recover plaintext.
- Adds a valid/ready handshake on both sides, so the keystream advances only per consumed byte and never free-runs out of step with the sender.
- Sits between the cipher byte source (bus/UART side) and the plaintext consumer.

Parameters:
- STEPS, 6, LFSR shifts per key byte; must equal the encryptor's shifts per byte.
- KEY_BITS, 6, keystream bits per byte, placed in key[KEY_BITS-1:0] with the upper bits zero.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seed  in  64  LFSR seed, sampled when load=1.
- load  in  1  reseeds the LFSR and restarts the keystream; one-cycle pulse.
- in_valid  in  1  cipher byte present.
- in_data  in  8  cipher byte.
- in_ready  out  1  block accepts a cipher byte this cycle.
- out_valid  out  1  plaintext byte held.
- out_data  out  8  plaintext byte.
- out_ready  in  1  consumer takes the plaintext byte.

Behaviour:
- LFSR step: lfsr <= {lfsr[1]^lfsr[0]^lfsr[4]^lfsr[3], lfsr[63:1]}.
- Keystream definition: S0 = seed and Sk = k steps of S0. Key byte n (n>=1) = {2'b00, S(STEPS*n)[63:58]}.
- FSM states:
  - IDLE: unseeded; in_ready=0.
  - GEN: stepping, with step counter cnt running 0..STEPS-1.
  - KEY: key byte held.
- IDLE->GEN on load.
- GEN:
  - Each cycle, lfsr steps and cnt++.
  - On the cycle with cnt==STEPS-1: the step completes, key <= {2'b00, next_lfsr[63:58]}, and the FSM goes to KEY.
  - GEN lasts exactly STEPS cycles. First key is ready STEPS cycles after the load edge.
- in_ready = (state==KEY) && (!out_valid || out_ready). This is combinational and never depends on in_valid.
- Accept = in_valid && in_ready. On accept:
  - out_data <= in_data ^ key; out_valid <= 1.
  - FSM -> GEN; cnt <= 0.
- Latency: accepted byte appears on out_data one cycle later.
- Throughput: 1 byte per STEPS+1 cycles at best.
- Output hold: out_valid and out_data are stable while out_valid && !out_ready.
  - out_valid clears on an out_ready handshake unless a new accept occurs in the same cycle. Same-cycle pop+accept keeps out_valid=1 with the new data.
- Backpressure: in KEY with out_valid=1 and out_ready=0, in_ready=0. The LFSR and key hold.
- load takes priority over everything, in any state:
  - lfsr <= seed; cnt <= 0; FSM -> GEN; out_valid <= 0. The pending plaintext is discarded.
  - Any simultaneous accept is ignored, and in_ready is forced 0 in that cycle.
- rst takes priority over load:
  - FSM=IDLE, lfsr=0, key=0, cnt=0, out_valid=0, out_data=8'h00, in_ready=0.
  - Reset mid-GEN or mid-hold drops all state; a new load is required.
- Seed all zero is legal: the LFSR stays 0, every key is 8'h00, and plaintext equals ciphertext. No error flag.
- Bits [7:KEY_BITS] of in_data pass through unmodified.

Decomposition:
- Package stream_cipher_pkg holds:
  - LFSR_W=64, TAP positions {0,1,3,4}, KEY_BITS and STEPS defaults.
  - A lfsr_next(64b) function.
  - The state enum {IDLE, GEN, KEY}.
  - The package is shared with the encryptor so the taps can never diverge.
- One sub-module, lfsr_keystream, owns the LFSR register, the step counter and the key register, and raises a key_valid strobe.
- The top level keeps the FSM handshake and output register.

Test Plan:
- rst held 2 cycles -> in_ready=0, out_valid=0, out_data=8'h00. With no load, in_valid=1 is never accepted.
- seed=64'h0000_0000_0000_000F, load pulse, then in_valid=1 with in_data=8'h5A -> in_ready rises exactly 6 cycles after the load edge. Key=8'h09; out_data=8'h53 one cycle after accept.
- seed=0, stream 8'hA5, 8'h3C, out_ready=1 -> outputs 8'hA5, 8'h3C. Accepts are spaced 7 cycles apart.
- Random seed with a 32-byte stream encrypted by a golden keystream model -> decrypted bytes equal the original plaintext.
  - Repeat with out_ready randomly low: no loss, no duplicates, out_data stable while stalled.
- load asserted while out_valid=1 and in_valid=1 -> no accept that cycle, out_valid=0 next cycle. The keystream restarts from the new seed.
- rst asserted mid-GEN (cnt=3) -> IDLE next cycle, lfsr=0. A subsequent load with the same seed reproduces key byte 1.
